// File: rtl/stopwatch_mux_ssd.sv
// Stopwatch with run/pause/lap control: a packed-BCD up-counter advanced by a prescaler,
// shown on a time-multiplexed, active-high seven-segment display.
module stopwatch_mux_ssd #(
   parameter int N_DIGITS = 4,
   parameter int TICK_DIV = 1_250_000,
   parameter int SCAN_DIV = 125_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                clr,
   input  logic                lap,
   output logic [N_DIGITS-1:0] seg_en,
   output logic [6:0]          ssd,
   output logic                running,
   output logic                wrap
);
   localparam int CW = 4 * N_DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [N_DIGITS-1:0] SEG_EN_FIRST = {{(N_DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d, count_inc_s;
   logic [CW-1:0]       cap_q, cap_d, disp_s;
   logic [PW-1:0]       presc_q, presc_d;
   logic [SW-1:0]       scan_q, scan_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                lap_q;
   logic [N_DIGITS-1:0] seg_en_q, seg_en_d;
   logic [6:0]          ssd_q, ssd_d;
   logic                running_q, running_d;
   logic                wrap_q, wrap_d;
   logic                lap_edge_s, clear_s, advance_s, tick_s, carry_s;
   logic [3:0]          digit_s;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   // Controller: next state, lap capture and clear request.
   always_comb begin
      state_d    = state_q;
      cap_d      = cap_q;
      clear_s    = 1'b0;
      lap_edge_s = lap & ~lap_q;
      case (state_q)
         IDLE, PAUSE: begin
            if (clr) begin
               state_d = IDLE;
               clear_s = 1'b1;
            end else if (start & ~stop) begin
               state_d = RUN;
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = PAUSE;
            end else if (lap_edge_s) begin
               state_d = LAP;
               cap_d   = count_q;
            end else begin
               state_d = RUN;
            end
         end
         LAP: begin
            if (stop) begin
               state_d = PAUSE;
            end else if (lap_edge_s) begin
               state_d = RUN;
            end else begin
               state_d = LAP;
            end
         end
         default: state_d = IDLE;
      endcase
      running_d = (state_d == RUN) || (state_d == LAP);
      // The stop edge itself does not advance, so a resume continues from the held phase.
      advance_s = running_d && ((state_q == RUN) || (state_q == LAP));
   end

   // Prescaler and BCD count with full-width carry ripple.
   always_comb begin
      tick_s = 1'b0;
      if (clear_s) begin
         presc_d = '0;
      end else if (advance_s) begin
         if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_s  = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = presc_q;
      end
      count_inc_s = count_q;
      carry_s     = tick_s;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (carry_s) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               count_inc_s[4*i +: 4] = 4'd0;
            end else begin
               count_inc_s[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry_s               = 1'b0;
            end
         end else begin
            count_inc_s[4*i +: 4] = count_q[4*i +: 4];
         end
      end
      wrap_d = carry_s;
      if (clear_s) begin
         count_d = '0;
      end else begin
         count_d = count_inc_s;
      end
   end

   // Digit scan and segment decode of the displayed value.
   always_comb begin
      if (scan_q == SW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         if (idx_q == IW'(N_DIGITS - 1)) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end else begin
         scan_d = scan_q + SW'(1);
         idx_d  = idx_q;
      end
      disp_s   = (state_q == LAP) ? cap_q : count_q;
      digit_s  = 4'(disp_s >> {idx_q, 2'b00});
      seg_en_d = SEG_EN_FIRST << idx_q;
      ssd_d    = seg_decode(digit_s);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         cap_q     <= '0;
         presc_q   <= '0;
         scan_q    <= '0;
         idx_q     <= '0;
         lap_q     <= 1'b0;
         seg_en_q  <= SEG_EN_FIRST;
         ssd_q     <= 7'h3F;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         cap_q     <= cap_d;
         presc_q   <= presc_d;
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         lap_q     <= lap;
         seg_en_q  <= seg_en_d;
         ssd_q     <= ssd_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   assign seg_en  = seg_en_q;
   assign ssd     = ssd_q;
   assign running = running_q;
   assign wrap    = wrap_q;
endmodule

// File: tb/tb_stopwatch_mux_ssd.sv
// Bench for stopwatch_mux_ssd: an integer reference model queues expected outputs every
// cycle, while a control table and hand sequences check count, display and corner cases.
`timescale 1ns/1ps
module tb_stopwatch_mux_ssd;
   localparam int N    = 4;
   localparam int TICK = 4;
   localparam int SCAN = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

   logic         clk, rst, start, stop, clr, lap;
   logic [N-1:0] seg_en;
   logic [6:0]   ssd;
   logic         running, wrap;
   int           checks = 0;
   int           errors = 0;

   stopwatch_mux_ssd #(.N_DIGITS(N), .TICK_DIV(TICK), .SCAN_DIV(SCAN)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .lap(lap),
      .seg_en(seg_en), .ssd(ssd), .running(running), .wrap(wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         running;
      logic         wrap;
      logic [N-1:0] seg_en;
      logic [6:0]   ssd;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      bit r, s, p, c, l;
      int cycles;
      int exp_count;
      int exp_disp;
      bit exp_running;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
      endcase
   endfunction

   function automatic int pow10(input int e);
      int p = 1;
      for (int i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   function automatic int bcd2int(input logic [4*N-1:0] b);
      int v = 0;
      for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic void add(input bit r, s, p, c, l, input int cyc, cnt, dsp, input bit run);
      vec_t v;
      v.r = r; v.s = s; v.p = p; v.c = c; v.l = l;
      v.cycles = cyc; v.exp_count = cnt; v.exp_disp = dsp; v.exp_running = run;
      vecs.push_back(v);
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_seg(input logic [N-1:0] target, input int limit);
      int n = 0;
      while (seg_en !== target && n < limit) begin
         step(1);
         n++;
      end
      checks++;
      if (seg_en !== target) begin
         errors++;
         $display("FAIL wait_seg: got seg_en=%b expected %b within %0d cycles", seg_en, target, limit);
      end
   endtask

   // Reference model: advances on every rising edge, queues the outputs due after it.
   initial begin : model
      int   st, ns, cnt, cap, presc, scan, idx, disp;
      bit   lapq, lap_rise, adv;
      exp_t e;
      st = M_IDLE; cnt = 0; cap = 0; presc = 0; scan = 0; idx = 0; lapq = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            st = M_IDLE; cnt = 0; cap = 0; presc = 0; scan = 0; idx = 0; lapq = 1'b0;
            e.running = 1'b0; e.wrap = 1'b0; e.seg_en = '0; e.seg_en[0] = 1'b1; e.ssd = 7'h3F;
         end else begin
            disp       = (st == M_LAP) ? cap : cnt;
            e.seg_en   = '0;
            e.seg_en[idx] = 1'b1;
            e.ssd      = ref_seg((disp / pow10(idx)) % 10);
            if (scan == SCAN - 1) begin
               scan = 0;
               idx  = (idx + 1) % N;
            end else begin
               scan = scan + 1;
            end
            lap_rise = lap && !lapq;
            lapq     = lap;
            ns       = st;
            if (st == M_IDLE || st == M_PAUSE) begin
               if (clr) ns = M_IDLE;
               else if (start && !stop) ns = M_RUN;
            end else if (stop) begin
               ns = M_PAUSE;
            end else if (lap_rise) begin
               ns = (st == M_RUN) ? M_LAP : M_RUN;
            end
            adv = (st == M_RUN || st == M_LAP) && (ns == M_RUN || ns == M_LAP);
            if (st == M_RUN && ns == M_LAP) cap = cnt;
            e.wrap = 1'b0;
            if (clr && (st == M_IDLE || st == M_PAUSE)) begin
               cnt = 0; presc = 0;
            end else if (adv) begin
               if (presc == TICK - 1) begin
                  presc = 0;
                  if (cnt == pow10(N) - 1) e.wrap = 1'b1;
                  cnt = (cnt + 1) % pow10(N);
               end else begin
                  presc = presc + 1;
               end
            end
            st        = ns;
            e.running = (ns == M_RUN || ns == M_LAP);
         end
         sb_q.push_back(e);
      end
   end

   // Scoreboard: compare queued expectations on the falling edge.
   initial begin : sb_check
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (running !== e.running || wrap !== e.wrap || seg_en !== e.seg_en || ssd !== e.ssd) begin
               errors++;
               $display("FAIL scoreboard @%0t: got run=%b wrap=%b seg_en=%b ssd=%h expected run=%b wrap=%b seg_en=%b ssd=%h",
                        $time, running, wrap, seg_en, ssd, e.running, e.wrap, e.seg_en, e.ssd);
            end
         end
      end
   end

   initial begin : main
      logic [6:0]   exp_ssd [4];
      logic [N-1:0] one_hot;
      rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; lap = 1'b0;

      //   r  s  p  c  l  cyc   count disp run
      add(1, 0, 0, 0, 0,    3,    0,    0, 0);
      add(0, 1, 0, 0, 0,    1,    0,    0, 1);
      add(0, 0, 0, 0, 0,    3,    0,    0, 1);
      add(0, 0, 0, 0, 0,    1,    1,    1, 1);
      add(0, 0, 0, 0, 0,   36,   10,   10, 1);
      add(0, 0, 0, 0, 0,    2,   10,   10, 1);
      add(0, 0, 1, 0, 0,    1,   10,   10, 0);
      add(0, 0, 0, 0, 0,    5,   10,   10, 0);
      add(0, 1, 0, 0, 0,    1,   10,   10, 1);
      add(0, 0, 0, 0, 0,    1,   10,   10, 1);
      add(0, 0, 0, 0, 0,    1,   11,   11, 1);
      add(0, 0, 0, 0, 0,    4,   12,   12, 1);
      add(0, 0, 0, 0, 1,    1,   12,   12, 1);
      add(0, 0, 0, 0, 0,   11,   15,   12, 1);
      add(0, 0, 0, 0, 1,    3,   15,   15, 1);
      add(0, 0, 0, 0, 0,    1,   16,   16, 1);
      add(0, 0, 1, 0, 0,    1,   16,   16, 0);
      add(0, 1, 0, 1, 0,    1,    0,    0, 0);
      add(0, 1, 1, 0, 0,    2,    0,    0, 0);
      add(0, 1, 0, 0, 0,    1,    0,    0, 1);
      add(0, 0, 0, 1, 0,    3,    0,    0, 1);
      add(0, 0, 0, 1, 0,    1,    1,    1, 1);
      add(0, 0, 0, 0, 1,    1,    1,    1, 1);
      add(0, 0, 0, 0, 0,    7,    3,    1, 1);
      add(0, 0, 1, 0, 0,    1,    3,    3, 0);
      add(0, 0, 0, 1, 0,    1,    0,    0, 0);
      add(0, 1, 0, 0, 0,    1,    0,    0, 1);
      add(0, 0, 0, 0, 0, 4936, 1234, 1234, 1);
      add(0, 0, 1, 0, 0,    1, 1234, 1234, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].r; start = vecs[i].s; stop = vecs[i].p; clr = vecs[i].c; lap = vecs[i].l;
         step(vecs[i].cycles);
         check_val($sformatf("row%0d_count", i), bcd2int(dut.count_q), vecs[i].exp_count);
         check_val($sformatf("row%0d_disp", i), bcd2int(dut.disp_s), vecs[i].exp_disp);
         check_val($sformatf("row%0d_running", i), {31'd0, running}, {31'd0, vecs[i].exp_running});
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; lap = 1'b0;

      // Digit scan of a paused 1234, then reset in the middle of the scan.
      exp_ssd[0] = 7'h66; exp_ssd[1] = 7'h4F; exp_ssd[2] = 7'h5B; exp_ssd[3] = 7'h06;
      wait_seg(4'b1000, 12);
      wait_seg(4'b0001, 4);
      for (int k = 0; k < 4; k++) begin
         one_hot = 4'b0001 << k;
         for (int j = 0; j < 2; j++) begin
            check_val($sformatf("scan%0d_seg_en", k), {28'd0, seg_en}, {28'd0, one_hot});
            check_val($sformatf("scan%0d_ssd", k), {25'd0, ssd}, {25'd0, exp_ssd[k]});
            step(1);
         end
      end
      step(4);
      check_val("pre_rst_seg_en", {28'd0, seg_en}, 32'd4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_val("rst_seg_en", {28'd0, seg_en}, 32'd1);
      check_val("rst_ssd", {25'd0, ssd}, 32'h3F);
      check_val("rst_count", bcd2int(dut.count_q), 32'd0);
      step(1);
      check_val("rst_hold_seg_en", {28'd0, seg_en}, 32'd1);

      // Reset while in LAP overrides a simultaneous start.
      start = 1'b1; step(1); start = 1'b0;
      lap = 1'b1; step(1); lap = 1'b0;
      step(6);
      check_val("lap_count", bcd2int(dut.count_q), 32'd1);
      check_val("lap_disp", bcd2int(dut.disp_s), 32'd0);
      rst = 1'b1; start = 1'b1;
      step(1);
      check_val("rst_lap_running", {31'd0, running}, 32'd0);
      check_val("rst_lap_disp", bcd2int(dut.disp_s), 32'd0);
      rst = 1'b0; start = 1'b0;
      step(2);
      check_val("post_rst_running", {31'd0, running}, 32'd0);
      check_val("post_rst_count", bcd2int(dut.count_q), 32'd0);

      // Roll over from 9999.
      start = 1'b1; step(1); start = 1'b0;
      step(39996);
      check_val("count_9999", bcd2int(dut.count_q), 32'd9999);
      step(3);
      check_val("pre_wrap_count", bcd2int(dut.count_q), 32'd9999);
      check_val("pre_wrap", {31'd0, wrap}, 32'd0);
      step(1);
      check_val("wrap_count", bcd2int(dut.count_q), 32'd0);
      check_val("wrap_pulse", {31'd0, wrap}, 32'd1);
      step(1);
      check_val("wrap_single", {31'd0, wrap}, 32'd0);
      step(3);
      check_val("post_wrap_count", bcd2int(dut.count_q), 32'd1);
      check_val("post_wrap_running", {31'd0, running}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
